// File: rtl/alu_issue.sv
// ALU issue stage: decodes RV32I OP/OP-IMM into a one-hot ALU command with
// XLEN+1-bit operands and queues results in a 2-entry skid buffer toward execute.
package riscv;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned NB_OPERATION = 5;
  localparam int unsigned ADD          = 0;
  localparam int unsigned SLT          = 1;
  localparam int unsigned AND          = 2;
  localparam int unsigned OR           = 3;
  localparam int unsigned XOR          = 4;
endpackage

module alu_issue
  import riscv::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    instr_valid_i,
  output logic                    instr_ready_o,
  input  logic [31:0]             instr_i,
  output logic [4:0]              rs1_adr_o,
  output logic [4:0]              rs2_adr_o,
  input  logic [XLEN-1:0]         rs1_rf_data_i,
  input  logic [XLEN-1:0]         rs2_rf_data_i,
  input  logic                    flush_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [XLEN:0]           rs1_data_o,
  output logic [XLEN:0]           rs2_data_o,
  output logic                    alu_en_o,
  output logic [NB_OPERATION-1:0] cmd_o,
  output logic [4:0]              rd_adr_o,
  output logic                    illegal_o
);

  typedef struct packed {
    logic [XLEN:0]           op1;
    logic [XLEN:0]           op2;
    logic [NB_OPERATION-1:0] cmd;
    logic [4:0]              rd;
    logic                    illegal;
  } entry_t;

  logic [1:0] r_cnt;
  logic       r_rdy;
  entry_t     r_ent0, r_ent1;

  logic [1:0]              w_cnt_nxt;
  logic                    w_push, w_pop;
  logic [6:0]              w_opc, w_f7;
  logic [2:0]              w_f3;
  logic [XLEN-1:0]         w_a, w_b, w_rs2, w_imm;
  logic [XLEN:0]           w_ea, w_eb;
  logic                    w_is_op, w_is_imm, w_legal, w_sub, w_uns;
  logic [NB_OPERATION-1:0] w_cmd;
  entry_t                  w_new;

  assign rs1_adr_o = instr_i[19:15];
  assign rs2_adr_o = instr_i[24:20];
  assign w_opc     = instr_i[6:0];
  assign w_f3      = instr_i[14:12];
  assign w_f7      = instr_i[31:25];
  assign w_imm     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign w_a       = (rs1_adr_o == 5'd0) ? '0 : rs1_rf_data_i;
  assign w_rs2     = (rs2_adr_o == 5'd0) ? '0 : rs2_rf_data_i;
  assign w_is_op   = (w_opc == 7'b0110011);
  assign w_is_imm  = (w_opc == 7'b0010011);

  always_comb begin
    w_cmd   = '0;
    w_sub   = 1'b0;
    w_uns   = 1'b0;
    w_legal = 1'b0;
    w_b     = w_is_imm ? w_imm : w_rs2;
    case (w_f3)
      3'b000: w_cmd[ADD] = 1'b1;
      3'b010: w_cmd[SLT] = 1'b1;
      3'b011: w_cmd[SLT] = 1'b1;
      3'b100: w_cmd[XOR] = 1'b1;
      3'b110: w_cmd[OR]  = 1'b1;
      3'b111: w_cmd[AND] = 1'b1;
      default: w_cmd = '0;
    endcase
    // SUB is the only OP encoding with a nonzero funct7; shifts have no cmd bit
    if (w_cmd != '0) begin
      w_legal = w_is_imm || (w_is_op && (w_f7 == 7'b0000000 ||
                (w_f3 == 3'b000 && w_f7 == 7'b0100000)));
    end
    w_uns = (w_f3 == 3'b011);
    w_sub = (w_f3 == 3'b010) || (w_f3 == 3'b011) ||
            (w_is_op && w_f3 == 3'b000 && w_f7 == 7'b0100000);
  end

  assign w_ea = w_uns ? {1'b0, w_a} : {w_a[XLEN-1], w_a};
  assign w_eb = w_uns ? {1'b0, w_b} : {w_b[XLEN-1], w_b};

  always_comb begin
    w_new         = '0;
    w_new.rd      = instr_i[11:7];
    w_new.illegal = ~w_legal;
    if (w_legal) begin
      w_new.op1 = w_ea;
      w_new.op2 = w_sub ? (~w_eb + {{XLEN{1'b0}}, 1'b1}) : w_eb;
      w_new.cmd = w_cmd;
    end
  end

  assign w_push = instr_valid_i & r_rdy & ~flush_i;
  assign w_pop  = (r_cnt != 2'd0) & ready_i;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (flush_i)              w_cnt_nxt = 2'd0;
    else if (w_push & ~w_pop) w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop & ~w_push) w_cnt_nxt = r_cnt - 2'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= 2'd0;
      r_rdy  <= 1'b0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      // head takes the new entry when it would otherwise be empty after this edge
      if (w_push && (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))) r_ent0 <= w_new;
      else if (w_pop && r_cnt == 2'd2)                           r_ent0 <= r_ent1;
      if (w_push && r_cnt == 2'd1 && !w_pop)                     r_ent1 <= w_new;
    end
  end

  assign instr_ready_o = r_rdy;
  assign valid_o       = (r_cnt != 2'd0);
  assign illegal_o     = valid_o & r_ent0.illegal;
  assign alu_en_o      = valid_o & ~r_ent0.illegal;
  assign rs1_data_o    = r_ent0.op1;
  assign rs2_data_o    = r_ent0.op2;
  assign cmd_o         = r_ent0.cmd;
  assign rd_adr_o      = r_ent0.rd;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Producer side of the ALU operand/command interface.
- Accepts decoded-stage instructions over a valid/ready handshake and reads rs1/rs2 from the register-file read ports.
- Decodes RV32I OP and OP-IMM ALU instructions into the one-hot ALU command and formats both operands to XLEN+1 bits, so the ALU's single adder also implements SUB/SLT/SLTU.
- Results are buffered in a 2-entry skid buffer toward execute; ready toward decode is always driven from registered state.

Parameters:
- XLEN, 32 (riscv package): architectural data width.
- NB_OPERATION, riscv package: width of one-hot command; bit indices ADD, SLT, AND, OR, XOR from package.
- Module-local parameters: none.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- instr_valid_i  in  1  instruction valid from decode.
- instr_ready_o  out  1  block can accept an instruction.
- instr_i  in  32  instruction word.
- rs1_adr_o  out  5  RF read address 1 = instr_i[19:15], combinational.
- rs2_adr_o  out  5  RF read address 2 = instr_i[24:20], combinational.
- rs1_rf_data_i  in  XLEN  RF read data 1, same cycle.
- rs2_rf_data_i  in  XLEN  RF read data 2, same cycle.
- flush_i  in  1  discard all buffered entries.
- valid_o  out  1  head entry valid toward execute.
- ready_i  in  1  execute accepts head entry.
- rs1_data_o  out  XLEN+1  formatted operand 1.
- rs2_data_o  out  XLEN+1  formatted operand 2.
- alu_en_o  out  1  valid_o & ~illegal_o.
- cmd_o  out  NB_OPERATION  one-hot ALU command, all-zero when illegal.
- rd_adr_o  out  5  destination register instr[11:7].
- illegal_o  out  1  head entry is not a supported ALU instruction.

Behaviour:
- Reset (reset_n low, asynchronous):
  - Buffer count = 0.
  - valid_o, alu_en_o, illegal_o = 0; cmd_o, operands and rd_adr_o = 0.
  - instr_ready_o forced 0 while reset_n is low; it is 1 from the first clk edge after release.
- Accept:
  - Accept occurs when instr_valid_i & instr_ready_o at a rising edge.
  - instr_ready_o = (count < 2), registered state only, with no combinational path from ready_i.
- Latency: an instruction accepted into an empty buffer appears on valid_o in the next cycle.
- Output transfer:
  - Transfer occurs when valid_o & ready_i; the head entry pops.
  - Simultaneous accept and pop at count 2 is impossible, because ready_o = 0.
  - At count 1 the count stays 1 and the new entry becomes head.
- Ordering: strict FIFO, and outputs are stable while valid_o & ~ready_i.
- Flush:
  - flush_i clears count to 0 at the next edge, and valid_o = 0 the following cycle.
  - Flush wins over a same-cycle accept; that instruction is dropped.
- Decode (opcode instr[6:0], funct3 instr[14:12], funct7 instr[31:25]):
  - OP 0110011:
    - 000/f7 0000000 = ADD.
    - 000/f7 0100000 = SUB.
    - 010 = SLT; 011 = SLTU; 100 = XOR; 110 = OR; 111 = AND.
    - Any other funct7 value on these encodings is illegal.
  - OP-IMM 0010011: 000 ADDI, 010 SLTI, 011 SLTIU, 100 XORI, 110 ORI, 111 ANDI; imm = sext(instr[31:20]).
  - Shifts (funct3 001/101), all other opcodes, and funct7 mismatches are illegal.
- Operand source: x0 reads are forced to 0 by this block when the address is 0; the RF value is ignored.
- Operand formatting (a = rs1 value, b = rs2 value or imm):
  - ADD/ADDI, AND/ANDI, OR/ORI, XOR/XORI: op1 = sext(a), op2 = sext(b); cmd ADD/AND/OR/XOR respectively.
  - SUB: op1 = sext(a), op2 = (~sext(b) + 1) mod 2^(XLEN+1); cmd ADD.
  - SLT/SLTI: same operands as SUB; cmd SLT. The ALU sum bit XLEN is the signed a<b.
  - SLTU/SLTIU: op1 = zext(a), op2 = (~zext(b) + 1) mod 2^(XLEN+1); cmd SLT. For SLTIU, b = sext imm to XLEN, then zero-extended.
  - Illegal: op1 = op2 = 0, cmd = 0, illegal_o = 1, alu_en_o = 0. The entry is still delivered and popped normally.
- Exactly one cmd_o bit is set for a legal entry.

Test Plan:
- Reset, then ADD x3,x1,x2 with x1=5, x2=7 -> next cycle valid_o=1, cmd ADD, rs1_data_o=0x0_00000005, rs2_data_o=0x0_00000007, rd_adr_o=3.
- SLT x1=0xFFFFFFFF (-1), x2=1 -> rs2_data_o=0x1_FFFFFFFF, cmd SLT; ALU sum bit 32 = 1. SLTU with the same values -> rs1_data_o=0x0_FFFFFFFF, rs2_data_o=0x1_FFFFFFFF, sum bit 32 = 0.
- SLTIU imm=0xFFF with x1=3 -> rs2_data_o=0x1_00000001, cmd SLT, sum bit 32 = 1. Same instruction with rs1 field = x0 -> rs1_data_o=0.
- ready_i held 0 while 3 instructions are offered -> first two accepted, instr_ready_o=0 on the 3rd. Release ready_i -> outputs in order, no loss or duplication.
- SLLI and funct7=0000001 (MUL) -> valid_o=1, illegal_o=1, alu_en_o=0, cmd_o=0.
- flush_i with 2 buffered entries plus a same-cycle instr_valid_i -> valid_o=0 next cycle and count 0; the dropped instruction never appears. reset_n asserted mid-stall -> all outputs 0 immediately.
